// File: rtl/lsu_if.sv
// lsu_if: decode request/response and data-cache bus bundle for the load/store unit
interface lsu_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  localparam int NB = DATA_WIDTH / 8;
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] resp_data;
  logic                  resp_err;
  logic                  dc_req;
  logic                  dc_we;
  logic [ADDR_WIDTH-1:0] dc_addr;
  logic [DATA_WIDTH-1:0] dc_wdata;
  logic [NB-1:0]         dc_be;
  logic                  dc_valid;
  logic [DATA_WIDTH-1:0] dc_rdata;
  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, dc_valid, dc_rdata,
    output req_ready, resp_valid, resp_data, resp_err, dc_req, dc_we, dc_addr, dc_wdata, dc_be
  );
  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, dc_valid, dc_rdata,
    input  req_ready, resp_valid, resp_data, resp_err, dc_req, dc_we, dc_addr, dc_wdata, dc_be
  );
endinterface

// File: rtl/lsu_aligned.sv
// lsu_aligned: single-outstanding load/store unit with lane alignment, load extension and cache timeout
module lsu_aligned #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic  clk,
  input logic  rst,
  lsu_if.slave bus
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int LB = $clog2(NB);
  localparam int CW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t                state_q, state_d;
  logic                  we_q, uns_q, err_q;
  logic [1:0]            size_q;
  logic [LB-1:0]         lane_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, data_q, s, m, ld;
  logic [NB-1:0]         be_q;
  logic [CW-1:0]         cnt_q;
  logic                  acc, mis, tmo, sb;
  logic [2:0]            amask;
  logic [7:0]            bmask;
  logic [LB-1:0]         lane;
  assign lane  = bus.req_addr[LB-1:0];
  assign amask = 3'((4'd1 << bus.req_size) - 4'd1);
  assign bmask = 8'((9'd1 << (4'd1 << bus.req_size)) - 9'd1);
  assign mis   = (|(bus.req_addr[2:0] & amask)) | (bus.req_size == 2'd3 && DATA_WIDTH == 32);
  assign acc   = bus.req_valid & bus.req_ready;
  assign tmo   = (TIMEOUT_CYCLES != 0) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  // dc_valid beats a same-cycle timeout because it is checked first
  always_comb begin
    state_d = state_q;
    if (acc) state_d = mis ? RESP : BUSY;
    else if (state_q == RESP) state_d = IDLE;
    else if (state_q == BUSY && (bus.dc_valid || tmo)) state_d = RESP;
  end
  always_comb begin
    m = '0;
    for (int i = 0; i < NB; i++) m[8*i +: 8] = {8{i < (1 << size_q)}};
    s  = bus.dc_rdata >> {lane_q, 3'b000};
    sb = size_q == 2'd0 ? s[7] : size_q == 2'd1 ? s[15] : size_q == 2'd2 ? s[31] : s[DATA_WIDTH-1];
    ld = (s & m) | ({DATA_WIDTH{sb & ~uns_q}} & ~m);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= '0;
      lane_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      be_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= state_q == BUSY ? cnt_q + 1'b1 : '0;
      if (acc) begin
        we_q    <= bus.req_we;
        uns_q   <= bus.req_unsigned;
        size_q  <= bus.req_size;
        lane_q  <= lane;
        err_q   <= mis;
        data_q  <= '0;
        addr_q  <= {bus.req_addr[ADDR_WIDTH-1:LB], LB'(0)};
        wdata_q <= bus.req_wdata << {lane, 3'b000};
        be_q    <= NB'(16'(bmask) << lane);
      end else if (state_q == BUSY && bus.dc_valid) begin
        err_q  <= 1'b0;
        data_q <= we_q ? '0 : ld;
      end else if (state_q == BUSY && tmo) begin
        err_q  <= 1'b1;
        data_q <= '0;
      end
    end
  end
  assign bus.req_ready  = ~rst & (state_q != BUSY);
  assign bus.resp_valid = state_q == RESP;
  assign bus.resp_err   = (state_q == RESP) & err_q;
  assign bus.resp_data  = state_q == RESP ? data_q : '0;
  assign bus.dc_req     = state_q == BUSY;
  assign bus.dc_we      = we_q;
  assign bus.dc_addr    = addr_q;
  assign bus.dc_wdata   = wdata_q;
  assign bus.dc_be      = be_q;
endmodule

// File: tb/tb_lsu_aligned.sv
// tb_lsu_aligned: directed and random checks of 32-bit and 64-bit LSU instances against an arithmetic model
module tb_lsu_aligned;
  logic clk = 1'b0;
  logic rst32, rst64;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  lsu_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) b32 ();
  lsu_if #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) b64 ();
  lsu_aligned #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(4)) d32 (.clk(clk), .rst(rst32), .bus(b32));
  lsu_aligned #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(16)) d64 (.clk(clk), .rst(rst64), .bus(b64));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // load result from the extension rules, using wide integer arithmetic
  function automatic logic [63:0] exp_ld(input int dw, input logic [63:0] rd, input int ln, input int nb, input logic uns);
    logic [127:0] s, top;
    top = 128'd1 << (8 * nb);
    s = (128'(rd) >> (8 * ln)) % top;
    if (!uns && s >= (top >> 1)) s = s + (128'd1 << dw) - top;
    return 64'(s);
  endfunction

  function automatic logic [63:0] exp_be(input int nb, input int ln);
    longint v;
    v = ((longint'(1) << nb) - 1) << ln;
    return 64'(v);
  endfunction

  task automatic op32(input logic we, input logic [1:0] sz, input logic uns, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] rd, input int lat);
    int nb, ln;
    bit mis;
    nb = 1 << sz;
    ln = int'(a % 4);
    mis = (a % nb != 0) || sz == 2'd3;
    b32.req_valid = 1'b1; b32.req_we = we; b32.req_size = sz; b32.req_unsigned = uns;
    b32.req_addr = a; b32.req_wdata = wd;
    chk("ready32", b32.req_ready, 1);
    @(negedge clk);
    b32.req_valid = 1'b0;
    if (mis) begin
      chk("mis_valid32", b32.resp_valid, 1);
      chk("mis_err32", b32.resp_err, 1);
      chk("mis_dcreq32", b32.dc_req, 0);
      chk("mis_data32", b32.resp_data, 0);
    end else begin
      chk("dcreq32", b32.dc_req, 1);
      chk("dcwe32", b32.dc_we, we);
      chk("dcaddr32", b32.dc_addr, a & ~32'd3);
      chk("dcbe32", b32.dc_be, exp_be(nb, ln) & 64'hF);
      chk("dcwdata32", b32.dc_wdata, (64'(wd) << (8 * ln)) & 64'hFFFF_FFFF);
      repeat (lat - 1) begin
        @(negedge clk);
        chk("hold_req32", b32.dc_req, 1);
        chk("hold_addr32", b32.dc_addr, a & ~32'd3);
        chk("hold_resp32", b32.resp_valid, 0);
      end
      b32.dc_valid = 1'b1; b32.dc_rdata = rd;
      @(negedge clk);
      b32.dc_valid = 1'b0;
      chk("resp_valid32", b32.resp_valid, 1);
      chk("resp_err32", b32.resp_err, 0);
      chk("resp_dcreq32", b32.dc_req, 0);
      chk("resp_data32", b32.resp_data, we ? 64'd0 : exp_ld(32, 64'(rd), ln, nb, uns));
    end
    @(negedge clk);
    chk("resp_once32", b32.resp_valid, 0);
  endtask

  task automatic op64(input logic we, input logic [1:0] sz, input logic uns, input logic [31:0] a,
                      input logic [63:0] wd, input logic [63:0] rd, input int lat);
    int nb, ln;
    bit mis;
    nb = 1 << sz;
    ln = int'(a % 8);
    mis = a % nb != 0;
    b64.req_valid = 1'b1; b64.req_we = we; b64.req_size = sz; b64.req_unsigned = uns;
    b64.req_addr = a; b64.req_wdata = wd;
    chk("ready64", b64.req_ready, 1);
    @(negedge clk);
    b64.req_valid = 1'b0;
    if (mis) begin
      chk("mis_valid64", b64.resp_valid, 1);
      chk("mis_err64", b64.resp_err, 1);
      chk("mis_dcreq64", b64.dc_req, 0);
    end else begin
      chk("dcreq64", b64.dc_req, 1);
      chk("dcaddr64", b64.dc_addr, a & ~32'd7);
      chk("dcbe64", b64.dc_be, exp_be(nb, ln) & 64'hFF);
      chk("dcwdata64", b64.dc_wdata, wd << (8 * ln));
      repeat (lat - 1) @(negedge clk);
      b64.dc_valid = 1'b1; b64.dc_rdata = rd;
      @(negedge clk);
      b64.dc_valid = 1'b0;
      chk("resp_valid64", b64.resp_valid, 1);
      chk("resp_err64", b64.resp_err, 0);
      chk("resp_data64", b64.resp_data, we ? 64'd0 : exp_ld(64, rd, ln, nb, uns));
    end
    @(negedge clk);
    chk("resp_once64", b64.resp_valid, 0);
  endtask

  initial begin
    rst32 = 1'b1; rst64 = 1'b1;
    b32.req_valid = 0; b32.req_we = 0; b32.req_size = 0; b32.req_unsigned = 0;
    b32.req_addr = 0; b32.req_wdata = 0; b32.dc_valid = 0; b32.dc_rdata = 0;
    b64.req_valid = 0; b64.req_we = 0; b64.req_size = 0; b64.req_unsigned = 0;
    b64.req_addr = 0; b64.req_wdata = 0; b64.dc_valid = 0; b64.dc_rdata = 0;
    repeat (3) @(negedge clk);
    chk("rst_ready", b32.req_ready, 0);
    chk("rst_dcreq", b32.dc_req, 0);
    chk("rst_valid", b32.resp_valid, 0);
    chk("rst_data", b32.resp_data, 0);
    chk("rst_be", b32.dc_be, 0);
    chk("rst_ready64", b64.req_ready, 0);
    rst32 = 1'b0; rst64 = 1'b0;
    @(negedge clk);
    chk("idle_ready", b32.req_ready, 1);
    chk("idle_valid", b32.resp_valid, 0);
    // directed cases
    op32(0, 2'd0, 0, 32'h1003, 32'h0, 32'h80FF_1234, 1);
    op32(1, 2'd1, 0, 32'h2002, 32'h0000_BEEF, 32'hDEAD_DEAD, 2);
    op32(0, 2'd2, 0, 32'h3001, 32'h0, 32'h0, 1);
    op32(0, 2'd3, 0, 32'h3008, 32'h0, 32'h0, 1);
    op32(0, 2'd1, 1, 32'h4002, 32'h0, 32'hA5A5_0000, 1);
    op32(0, 2'd2, 0, 32'h5004, 32'h0, 32'h8765_4321, 4);
    // timeout with late strobe
    b32.req_valid = 1; b32.req_we = 0; b32.req_size = 2'd2; b32.req_addr = 32'h6000;
    @(negedge clk);
    b32.req_valid = 0;
    for (int i = 0; i < 4; i++) begin
      chk("to_dcreq", b32.dc_req, 1);
      chk("to_novalid", b32.resp_valid, 0);
      @(negedge clk);
    end
    chk("to_valid", b32.resp_valid, 1);
    chk("to_err", b32.resp_err, 1);
    chk("to_dcreq_low", b32.dc_req, 0);
    b32.dc_valid = 1; b32.dc_rdata = 32'h1234_5678;
    @(negedge clk);
    chk("late_none", b32.resp_valid, 0);
    @(negedge clk);
    b32.dc_valid = 0;
    chk("late_none2", b32.resp_valid, 0);
    chk("late_ready", b32.req_ready, 1);
    // back-to-back: second request held through the RESP cycle
    b32.req_valid = 1; b32.req_we = 0; b32.req_size = 2'd2; b32.req_unsigned = 0; b32.req_addr = 32'h5000;
    @(negedge clk);
    chk("b2b_busy_ready", b32.req_ready, 0);
    b32.dc_valid = 1; b32.dc_rdata = 32'h1234_5678;
    b32.req_size = 2'd1; b32.req_unsigned = 1; b32.req_addr = 32'h4002;
    @(negedge clk);
    b32.dc_valid = 0;
    chk("b2b_v1", b32.resp_valid, 1);
    chk("b2b_d1", b32.resp_data, 32'h1234_5678);
    chk("b2b_ready", b32.req_ready, 1);
    @(negedge clk);
    b32.req_valid = 0;
    chk("b2b_gap", b32.resp_valid, 0);
    chk("b2b_dcreq", b32.dc_req, 1);
    chk("b2b_addr", b32.dc_addr, 32'h4000);
    chk("b2b_be", b32.dc_be, 4'b1100);
    b32.dc_valid = 1; b32.dc_rdata = 32'hA5A5_0000;
    @(negedge clk);
    b32.dc_valid = 0;
    chk("b2b_v2", b32.resp_valid, 1);
    chk("b2b_d2", b32.resp_data, 32'h0000_A5A5);
    @(negedge clk);
    chk("b2b_end", b32.resp_valid, 0);
    // random operations on the 32-bit instance
    for (int n = 0; n < 40; n++)
      op32(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom, $urandom, int'($urandom_range(1, 4)));
    // 64-bit instance
    op64(0, 2'd3, 0, 32'h8, 64'h0, 64'h8123_4567_89AB_CDEF, 1);
    op64(0, 2'd2, 0, 32'hC, 64'h0, 64'h8000_0001_0000_0000, 2);
    op64(1, 2'd1, 0, 32'h16, 64'hBEEF, 64'h0, 1);
    for (int n = 0; n < 20; n++)
      op64(1'($urandom), 2'($urandom), 1'($urandom), $urandom, {$urandom, $urandom}, {$urandom, $urandom},
           int'($urandom_range(1, 3)));
    // reset while busy discards the operation
    b64.req_valid = 1; b64.req_we = 0; b64.req_size = 2'd3; b64.req_addr = 32'h10;
    @(negedge clk);
    b64.req_valid = 0;
    chk("rb_dcreq", b64.dc_req, 1);
    rst64 = 1'b1;
    @(negedge clk);
    chk("rb_dcreq_low", b64.dc_req, 0);
    chk("rb_novalid", b64.resp_valid, 0);
    rst64 = 1'b0;
    @(negedge clk);
    chk("rb_ready", b64.req_ready, 1);
    chk("rb_novalid2", b64.resp_valid, 0);
    chk("rb_idle", b64.dc_req, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lsu_aligned.md
# lsu_aligned

Parametrised load/store unit between decode and the data cache. It accepts one memory operation at a time through a valid/ready handshake. It generates byte enables and store-lane alignment from the address and access size, and sign- or zero-extends load data. It flags misaligned accesses and cache timeouts as errors instead of hanging. One request is outstanding at a time, and responses can be issued back-to-back.

## Interface
- DATA_WIDTH, 32: data bus width, 32 or 64; NB = DATA_WIDTH/8 byte lanes, LB = log2(NB).
- ADDR_WIDTH, 32: address width.
- TIMEOUT_CYCLES, 16: maximum BUSY cycles without dc_valid; 0 disables the timeout.
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  decode presents an operation.
- req_ready  out  1  LSU can accept; high in IDLE and RESP.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 byte, 1 half, 2 word, 3 double (legal only when DATA_WIDTH=64).
- req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  DATA_WIDTH  store data, right-justified.
- resp_valid  out  1  one-cycle response pulse.
- resp_data  out  DATA_WIDTH  extended load data; 0 for stores and errors.
- resp_err  out  1  qualifies resp_valid; set on misalignment or timeout.
- dc_req  out  1  level request to the cache, held until dc_valid or timeout.
- dc_we  out  1  write enable.
- dc_addr  out  ADDR_WIDTH  req_addr with the low LB bits cleared.
- dc_wdata  out  DATA_WIDTH  req_wdata << (8*lane).
- dc_be  out  NB  ((1<<2^size)-1) << lane.
- dc_valid  in  1  cache completion strobe.
- dc_rdata  in  DATA_WIDTH  cache read data, valid when dc_valid is high.

## Operation
- lane = req_addr[LB-1:0]; nbytes = 1 << req_size.
- An accepted request is misaligned if req_addr mod nbytes is not 0, or if req_size=3 with DATA_WIDTH=32.
- States: IDLE, BUSY, RESP.
  - IDLE: on req_valid && req_ready, latch we/size/unsigned/lane and drive the cache outputs from the registers.
    - Aligned: go to BUSY.
    - Misaligned: go to RESP with resp_err=1; no dc_req is issued.
  - BUSY: dc_req=1 and all dc_* outputs are stable.
    - On dc_valid: capture the result and go to RESP.
    - Otherwise, when the timeout counter reaches TIMEOUT_CYCLES-1 (and TIMEOUT_CYCLES>0): go to RESP with resp_err=1.
  - RESP: resp_valid=1 for exactly one cycle; req_ready=1.
    - A request accepted in this cycle is handled exactly as in IDLE (BUSY or error RESP).
    - Otherwise go to IDLE.
- Load result:
  - s = dc_rdata >> (8*lane), truncated to nbytes.
  - Extend to DATA_WIDTH with bit 8*nbytes-1 of s if req_unsigned=0; otherwise extend with zeros.
  - size=3 on 64-bit, or size=2 on 32-bit, returns s unchanged.
- Store: resp_data=0 and resp_err=0 on completion.
- The timeout counter clears on entry to BUSY and counts each BUSY cycle.
- dc_valid outside BUSY is ignored; this includes a late strobe after a timeout.
- Reset mid-operation: the state returns to IDLE and dc_req drops in the cycle after rst is sampled. The pending operation is discarded and no response is issued.

## Timing
- Reset values: req_ready=0 while rst is high and 1 after it (IDLE); every other output is 0.
- Accept at edge T: dc_req is high from T+1.
- dc_valid sampled at edge T+k (k≥1): resp_valid is high during T+k+1 and dc_req is low in that cycle.
- Minimum load-to-response latency is 2 cycles. Back-to-back throughput is one operation per 2 cycles when the cache responds in 1 cycle.
- Misaligned request accepted at T: resp_valid=1 with resp_err=1 during T+1.
- Timeout: dc_req is high for exactly TIMEOUT_CYCLES cycles, then the error response follows in the next cycle.
- dc_valid and a timeout in the same cycle: dc_valid wins and the response carries no error.
- resp_valid has no backpressure; decode must consume it in the cycle it is asserted.

## Test plan
- Byte load, addr=0x1003, unsigned=0, dc_rdata=0x80FF_1234 (32-bit) -> dc_addr=0x1000, dc_be=4'b1000, resp_data=0xFFFF_FF80, resp_err=0.
- Half store, addr=0x2002, wdata=0x0000_BEEF -> dc_we=1, dc_be=4'b1100, dc_wdata=0xBEEF_0000; after dc_valid, resp_valid for one cycle with resp_data=0.
- Word load at addr=0x3001 -> dc_req never rises; resp_valid=1 and resp_err=1 exactly one cycle after accept.
- TIMEOUT_CYCLES=4, load with dc_valid held low -> dc_req high for 4 cycles, then an error response. A dc_valid arriving afterwards produces no second response.
- Back-to-back: a second req_valid held during the RESP cycle is accepted in that cycle. Expect alternating resp_valid pulses with a 1-cycle cache; an unsigned half load at 0x4002 with dc_rdata=0xA5A5_0000 returns 0x0000_A5A5.
- DATA_WIDTH=64: double load at 0x8 succeeds with dc_be=8'hFF. Assert rst while BUSY -> dc_req=0 and state IDLE next cycle, with no resp_valid.
